// File: rtl/instr_stream_feeder_pkg.sv
// Shared CPU definitions used by the instruction stream feeder.
// Provides the FIFO geometry, the instruction opcode constants, the feeder
// state encoding and a helper that extracts the opcode field of a word.
package cpu_defs;

  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int WORD_W = 16;

  localparam logic [4:0]        OP_NOP   = 5'b00000;
  localparam logic [4:0]        OP_HALT  = 5'b00001;
  localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  function automatic logic [4:0] opcode_of(input logic [WORD_W-1:0] word);
    return word[15:11];
  endfunction

endpackage

// File: rtl/instr_stream_feeder_if.sv
// Loader/CPU-side bus of the instruction stream feeder.
// slave  : the feeder (receives control + loader writes, drives stream/status)
// master : the environment (host loader and CPU control nets)
//   enable, start, flush     global control nets
//   wr_en, wr_data           loader write port
//   full, count, overflow    FIFO status
//   i_datain                 registered instruction word to the CPU
//   running, halted, underrun stream status
interface instr_stream_feeder_if;

  logic                          enable;
  logic                          start;
  logic                          flush;
  logic                          wr_en;
  logic [cpu_defs::WORD_W-1:0]   wr_data;
  logic                          full;
  logic [cpu_defs::AW:0]         count;
  logic [cpu_defs::WORD_W-1:0]   i_datain;
  logic                          running;
  logic                          halted;
  logic                          underrun;
  logic                          overflow;

  modport slave (
    input  enable, start, flush, wr_en, wr_data,
    output full, count, i_datain, running, halted, underrun, overflow
  );

  modport master (
    output enable, start, flush, wr_en, wr_data,
    input  full, count, i_datain, running, halted, underrun, overflow
  );

endinterface

// File: rtl/instr_stream_feeder_fifo.sv
// sync_fifo: single-clock FIFO holding instruction words for the feeder.
// Ports:
//   clock, reset         rising-edge clock, async active-low reset
//   wr, wdata            enqueue request (dropped when full unless popping)
//   rd, rdata            pop request; rdata is the current head (show-ahead)
//   clr                  empties the FIFO and clears overflow; wins over wr/rd
//   full, empty, count   occupancy status (full/empty derived from count)
//   overflow             sticky: a write was dropped because the FIFO was full
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr,
  input  logic [W-1:0]  wdata,
  input  logic          rd,
  output logic [W-1:0]  rdata,
  input  logic          clr,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rd_ok;
  logic          wr_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // A pop on the same edge frees a slot, so a write to a full FIFO still lands.
  assign rd_ok = rd && !empty && !clr;
  assign wr_ok = wr && !clr && (!full || rd_ok);

  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr && !wr_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_stream_feeder.sv
// instr_stream_feeder: buffers loader-written instruction words and, after a
// start pulse, streams one word per enabled clock onto the CPU's i_datain.
// Inserts NOP when starved and parks on NOP after issuing a HALT word.
// Ports:
//   clock   rising-edge system clock
//   reset   asynchronous active-low reset
//   bus     instr_stream_feeder_if.slave (control, loader writes, stream out)
//
// state   | meaning
// IDLE    | waiting for start; i_datain = NOP, no pops
// STREAM  | one word (or NOP if starved) per enabled edge
// HALTED  | HALT issued; i_datain = NOP, waiting for start or flush
module instr_stream_feeder
  import cpu_defs::*;
(
  input  logic                  clock,
  input  logic                  reset,
  instr_stream_feeder_if.slave  bus
);

  state_t              state, state_nxt;
  logic [WORD_W-1:0]   dout, dout_nxt;
  logic                underrun_q;
  logic                underrun_set;
  logic                pop;
  logic                clr;
  logic [WORD_W-1:0]   head;
  logic                fifo_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (WORD_W)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr       (bus.wr_en),
    .wdata    (bus.wr_data),
    .rd       (pop),
    .rdata    (head),
    .clr      (clr),
    .full     (bus.full),
    .empty    (fifo_empty),
    .count    (bus.count),
    .overflow (bus.overflow)
  );

  // Flush is a control action like any state change, so it also waits for enable.
  assign clr = bus.enable && bus.flush && (state != ST_STREAM);

  always_comb begin
    state_nxt    = state;
    dout_nxt     = dout;
    pop          = 1'b0;
    underrun_set = 1'b0;
    if (bus.enable) begin
      unique case (state)
        ST_IDLE: begin
          dout_nxt = NOP_WORD;
          if (bus.start && !bus.flush) state_nxt = ST_STREAM;
        end
        ST_STREAM: begin
          if (!fifo_empty) begin
            dout_nxt = head;
            pop      = 1'b1;
            if (opcode_of(head) == OP_HALT) state_nxt = ST_HALTED;
          end else begin
            dout_nxt     = NOP_WORD;
            underrun_set = 1'b1;
          end
        end
        ST_HALTED: begin
          dout_nxt = NOP_WORD;
          if (bus.flush)      state_nxt = ST_IDLE;
          else if (bus.start) state_nxt = ST_STREAM;
        end
        default: begin
          dout_nxt  = NOP_WORD;
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      dout       <= NOP_WORD;
      underrun_q <= 1'b0;
    end else begin
      state <= state_nxt;
      dout  <= dout_nxt;
      if (clr)               underrun_q <= 1'b0;
      else if (underrun_set) underrun_q <= 1'b1;
    end
  end

  assign bus.i_datain = dout;
  assign bus.running  = (state == ST_STREAM);
  assign bus.halted   = (state == ST_HALTED);
  assign bus.underrun = underrun_q;

endmodule

// File: tb/tb_instr_stream_feeder.sv
// Directed scoreboard bench for instr_stream_feeder. Stimulus pushes the
// expected stream words into exp_q; the monitor pops one per streamed word.
module tb_instr_stream_feeder;

  logic clock;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [15:0] exp_q[$];

  instr_stream_feeder_if bus();

  instr_stream_feeder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) $display("FAIL %s: got %0h, want %0h", name, act, req);
    else n_pass++;
  endtask

  // Monitor: a word is produced on every enabled edge taken while streaming.
  always @(posedge clock) begin
    logic was_run, was_en, was_rst;
    logic [15:0] want;
    was_run = bus.running;
    was_en  = bus.enable;
    was_rst = reset;
    #1;
    if (was_run && was_en && was_rst && reset) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {16'h0, bus.i_datain}, 32'hFFFF_FFFF);
      end else begin
        want = exp_q.pop_front();
        check("stream_word", {16'h0, bus.i_datain}, {16'h0, want});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wr(input logic [15:0] w);
    bus.wr_en   = 1'b1;
    bus.wr_data = w;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic wait_halted(input string name);
    for (int i = 0; i < 40 && !bus.halted; i++) tick();
    check(name, {31'h0, bus.halted}, 32'h1);
  endtask

  initial begin
    reset       = 1'b0;
    bus.enable  = 1'b1;
    bus.start   = 1'b0;
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 16'h0;
    tick(); tick();
    check("rst_count",    {27'h0, bus.count}, 32'h0);
    check("rst_datain",   {16'h0, bus.i_datain}, 32'h0);
    check("rst_flags",    {28'h0, bus.running, bus.halted, bus.underrun, bus.overflow}, 32'h0);
    check("rst_full",     {31'h0, bus.full}, 32'h0);
    reset = 1'b1;
    tick();

    // 1: async reset mid-stream with 5 words still queued
    for (int i = 1; i <= 6; i++) wr(16'h5000 + 16'(i));
    exp_q.push_back(16'h5001);
    pulse_start();
    tick();
    check("t1_count_before", {27'h0, bus.count}, 32'd5);
    check("t1_running",      {31'h0, bus.running}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("t1_rst_datain",  {16'h0, bus.i_datain}, 32'h0);
    check("t1_rst_count",   {27'h0, bus.count}, 32'h0);
    check("t1_rst_state",   {30'h0, bus.running, bus.halted}, 32'h0);
    tick();
    reset = 1'b1;
    tick();

    // 2: ADDI, NOP x3, HALT
    foreach (exp_q[i]) ;
    wr(16'h21FF); wr(16'h0000); wr(16'h0000); wr(16'h0000); wr(16'h0800);
    exp_q.push_back(16'h21FF); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0800);
    pulse_start();
    wait_halted("t2_halted");
    check("t2_halt_word", {16'h0, bus.i_datain}, 32'h0800);
    tick();
    check("t2_nop_after",  {16'h0, bus.i_datain}, 32'h0);
    check("t2_count",      {27'h0, bus.count}, 32'h0);
    check("t2_no_underrun", {31'h0, bus.underrun}, 32'h0);
    check("t2_sb_drain",   exp_q.size(), 32'h0);
    pulse_flush();
    check("t2_flush_idle", {30'h0, bus.running, bus.halted}, 32'h0);

    // 3: starvation inserts NOPs; flush is ignored while streaming
    wr(16'h1111); wr(16'h2222);
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    pulse_start();
    repeat (4) tick();
    bus.enable = 1'b0;
    check("t3_underrun", {31'h0, bus.underrun}, 32'h1);
    check("t3_running",  {31'h0, bus.running}, 32'h1);
    check("t3_sb_drain", exp_q.size(), 32'h0);
    wr(16'h0800);
    exp_q.push_back(16'h0800);
    bus.flush  = 1'b1;
    bus.enable = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("t3_flush_ign_halt", {31'h0, bus.halted}, 32'h1);
    check("t3_flush_ign_sticky", {31'h0, bus.underrun}, 32'h1);
    pulse_flush();
    check("t3_flush_clr", {29'h0, bus.underrun, bus.halted, bus.running}, 32'h0);

    // 4: full FIFO, pop+write while full, then a dropped write
    for (int i = 0; i < 16; i++) wr(16'h1000 + 16'(i));
    check("t4_full",        {31'h0, bus.full}, 32'h1);
    check("t4_count16",     {27'h0, bus.count}, 32'd16);
    check("t4_no_ovf",      {31'h0, bus.overflow}, 32'h0);
    exp_q.push_back(16'h1000);
    pulse_start();
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'h2000;
    tick();
    bus.wr_en  = 1'b0;
    bus.enable = 1'b0;
    check("t4_popwr_count", {27'h0, bus.count}, 32'd16);
    check("t4_popwr_no_ovf", {31'h0, bus.overflow}, 32'h0);
    wr(16'h2001);
    check("t4_ovf",         {31'h0, bus.overflow}, 32'h1);
    check("t4_ovf_count",   {27'h0, bus.count}, 32'd16);

    // 5: enable low freezes the stream
    exp_q.push_back(16'h1001); exp_q.push_back(16'h1002);
    bus.enable = 1'b1;
    tick(); tick();
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_frozen_data",  {16'h0, bus.i_datain}, 32'h1002);
      check("t5_frozen_count", {27'h0, bus.count}, 32'd14);
    end
    wr(16'h0800);
    for (int i = 3; i < 16; i++) exp_q.push_back(16'h1000 + 16'(i));
    exp_q.push_back(16'h2000);
    exp_q.push_back(16'h0800);
    bus.enable = 1'b1;
    wait_halted("t5_halted");
    check("t5_count",       {27'h0, bus.count}, 32'h0);
    check("t5_no_underrun", {31'h0, bus.underrun}, 32'h0);
    check("t5_sb_drain",    exp_q.size(), 32'h0);
    pulse_flush();
    check("t5_flush_ovf",   {31'h0, bus.overflow}, 32'h0);

    // 6a: restart from HALTED with 3 words left
    wr(16'h3001); wr(16'h0800); wr(16'h3002); wr(16'h3003); wr(16'h0800);
    exp_q.push_back(16'h3001); exp_q.push_back(16'h0800);
    pulse_start();
    wait_halted("t6_halted1");
    check("t6_left3", {27'h0, bus.count}, 32'd3);
    exp_q.push_back(16'h3002); exp_q.push_back(16'h3003); exp_q.push_back(16'h0800);
    pulse_start();
    wait_halted("t6_halted2");
    check("t6_left0", {27'h0, bus.count}, 32'h0);
    tick();
    check("t6_nop", {16'h0, bus.i_datain}, 32'h0);
    pulse_flush();

    // 6b: flush + start (+ write) on the same edge in HALTED
    wr(16'h4001); wr(16'h0800); wr(16'h4002);
    exp_q.push_back(16'h4001); exp_q.push_back(16'h0800);
    pulse_start();
    wait_halted("t6b_halted");
    check("t6b_left1", {27'h0, bus.count}, 32'd1);
    bus.flush   = 1'b1;
    bus.start   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'h4003;
    tick();
    bus.flush = 1'b0;
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    check("t6b_idle",   {30'h0, bus.running, bus.halted}, 32'h0);
    check("t6b_count",  {27'h0, bus.count}, 32'h0);
    check("t6b_datain", {16'h0, bus.i_datain}, 32'h0);
    tick(); tick();
    check("t6b_still_idle", {27'h0, bus.count, bus.running}, 32'h0);
    check("final_sb_drain", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
